led_chaser: RTL and testbench

LED_CHASER -- requirements
Module: led_chaser

---
 rtl/led_chaser.sv | 126 ++++++++++++
 tb/tb_led_chaser.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_chaser.sv
// LED chaser: prescaled pattern stepper (rotate-up/down, bounce, blink-all) with single-step.
// Optional LED_CHASER_PWM_EN adds a 4-bit brightness input and a PWM gate on leds.
module led_chaser #(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned TICK_DIV = 250000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [1:0]                  mode,
  input  logic                        step,
`ifdef LED_CHASER_PWM_EN
  input  logic [3:0]                  brightness,
`endif
  output logic [NUM_LEDS-1:0]         leds,
  output logic                        tick,
  output logic [$clog2(NUM_LEDS)-1:0] pos
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned XW = $clog2(NUM_LEDS);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [XW-1:0] POS_LAST = XW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [PW-1:0]       r_presc;
  logic [XW-1:0]       r_pos;
  dir_e                r_dir;
  logic                r_phase;
  logic                r_tick;
  logic [NUM_LEDS-1:0] r_pat;

  mode_e               w_mode;
  logic                w_adv;
  logic [XW-1:0]       w_pos_nx;
  dir_e                w_dir_nx;
  logic                w_phase_nx;
  logic [NUM_LEDS-1:0] w_pat_nx;

  always_comb begin
    w_mode     = mode_e'(mode);
    w_adv      = enable ? (r_presc == PRE_LAST) : step;
    w_pos_nx   = r_pos;
    w_dir_nx   = r_dir;
    w_phase_nx = 1'b0;
    case (w_mode)
      MODE_UP:   w_pos_nx = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
      MODE_DOWN: w_pos_nx = (r_pos == '0) ? POS_LAST : r_pos - 1'b1;
      MODE_BOUNCE: begin
        // Ends force the direction, which also covers entering bounce at an end.
        if (r_pos == POS_LAST)
          w_dir_nx = DIR_DOWN;
        else if (r_pos == '0)
          w_dir_nx = DIR_UP;
        w_pos_nx = (w_dir_nx == DIR_DOWN) ? r_pos - 1'b1 : r_pos + 1'b1;
      end
      MODE_BLINK: w_phase_nx = ~r_phase;
      default: ;
    endcase
    w_pat_nx = (w_mode == MODE_BLINK) ? {NUM_LEDS{w_phase_nx}}
                                      : (NUM_LEDS'(1) << w_pos_nx);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_presc <= '0;
    else if (enable)
      r_presc <= (r_presc == PRE_LAST) ? '0 : r_presc + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pos   <= '0;
      r_dir   <= DIR_UP;
      r_phase <= 1'b0;
      r_tick  <= 1'b0;
      r_pat   <= NUM_LEDS'(1);
    end else begin
      r_tick <= w_adv;
      if (w_adv) begin
        r_pos   <= w_pos_nx;
        r_dir   <= w_dir_nx;
        r_phase <= w_phase_nx;
        r_pat   <= w_pat_nx;
      end
    end
  end

`ifdef LED_CHASER_PWM_EN
  logic [3:0]          r_pwm;
  logic [NUM_LEDS-1:0] r_leds;
  logic                w_gate;

  assign w_gate = (brightness == 4'hF) || (r_pwm < brightness);

  // Gate the about-to-be-current pattern so leds still changes on the tick edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm  <= '0;
      r_leds <= NUM_LEDS'(1);
    end else begin
      r_pwm  <= r_pwm + 1'b1;
      r_leds <= (w_adv ? w_pat_nx : r_pat) & {NUM_LEDS{w_gate}};
    end
  end

  assign leds = r_leds;
`else
  assign leds = r_pat;
`endif

  assign tick = r_tick;
  assign pos  = r_pos;

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser (NUM_LEDS=4, TICK_DIV=4); PWM checks under LED_CHASER_PWM_EN.
module tb_led_chaser;

  localparam int N  = 4;
  localparam int TD = 4;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable  = 1'b0;
  logic         step    = 1'b0;
  logic [1:0]   mode    = 2'b00;
`ifdef LED_CHASER_PWM_EN
  logic [3:0]   brightness = 4'hF;
`endif
  logic [N-1:0] leds;
  logic         tick;
  logic [1:0]   pos;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_chaser #(.NUM_LEDS(N), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .mode       (mode),
    .step       (step),
`ifdef LED_CHASER_PWM_EN
    .brightness (brightness),
`endif
    .leds       (leds),
    .tick       (tick),
    .pos        (pos)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer counter, signed direction, explicit blink flag.
  typedef struct {
    int cnt;
    int pos;
    int dir;
    bit phase;
    bit blink;
    bit tick;
  } mst_t;

  function automatic mst_t rst_state();
    mst_t s;
    s.cnt = 0; s.pos = 0; s.dir = 1; s.phase = 1'b0; s.blink = 1'b0; s.tick = 1'b0;
    return s;
  endfunction

  function automatic mst_t nxt(mst_t s, logic en, logic st, logic [1:0] md);
    mst_t r;
    bit adv;
    r = s;
    adv = en ? (s.cnt == TD - 1) : st;
    if (en) r.cnt = (s.cnt + 1) % TD;
    r.tick = adv;
    if (adv) begin
      case (md)
        2'd0: r.pos = (s.pos + 1) % N;
        2'd1: r.pos = (s.pos + N - 1) % N;
        2'd2: begin
          if (s.pos == N - 1) r.dir = -1;
          else if (s.pos == 0) r.dir = 1;
          r.pos = s.pos + r.dir;
        end
        default: ;
      endcase
      r.phase = (md == 2'd3) ? !s.phase : 1'b0;
      r.blink = (md == 2'd3);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] pat(mst_t s);
    logic [N-1:0] v;
    if (s.blink) v = s.phase ? '1 : '0;
    else begin
      v = 1;
      v = v << s.pos;
    end
    return v;
  endfunction

  mst_t m = rst_state();
`ifdef LED_CHASER_PWM_EN
  int           m_pwm  = 0;
  logic [N-1:0] m_leds = 1;
`endif

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m <= rst_state();
`ifdef LED_CHASER_PWM_EN
      m_pwm  <= 0;
      m_leds <= 1;
`endif
    end else begin
      m <= nxt(m, enable, step, mode);
`ifdef LED_CHASER_PWM_EN
      m_pwm  <= (m_pwm + 1) % 16;
      m_leds <= pat(nxt(m, enable, step, mode)) &
                {N{(brightness == 4'hF) || (m_pwm < int'(brightness))}};
`endif
    end
  end

  function automatic logic [N-1:0] exp_leds();
`ifdef LED_CHASER_PWM_EN
    return m_leds;
`else
    return pat(m);
`endif
  endfunction

  always @(negedge clk) begin
    chk("model_leds", 32'(leds), 32'(exp_leds()));
    chk("model_tick", 32'(tick), 32'(m.tick));
    chk("model_pos",  32'(pos),  32'(m.pos));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (tick === 1'b1) begin
        n = i;
        return;
      end
    end
    chk("tick_timeout", 32'd0, 32'd1);
    n = 21;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    int nt;
    int cnt;
    logic [3:0] up_seq [4];
    logic [3:0] blink_seq [3];
    int bpos [7];
    up_seq    = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    blink_seq = '{4'b1111, 4'b0000, 4'b1111};
    bpos      = '{1, 2, 3, 2, 1, 0, 1};

    repeat (3) cyc();
    chk("rst_leds", 32'(leds), 32'h1);
    chk("rst_pos",  32'(pos),  32'h0);
    chk("rst_tick", 32'(tick), 32'h0);

    reset_n = 1'b1; enable = 1'b1; mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      chk("up_period", n, 4);
      chk("up_leds", 32'(leds), 32'(up_seq[i]));
    end

    mode = 2'd2;
    for (int i = 0; i < 7; i++) begin
      wait_tick(n);
      chk("bounce_pos", 32'(pos), bpos[i]);
    end

    mode = 2'd0;
    wait_tick(n);
    wait_tick(n);
    chk("up_to_end", 32'(pos), 3);
    mode = 2'd2;
    wait_tick(n);
    chk("bounce_enter_top", 32'(pos), 2);

    mode = 2'd0;
    cyc();
    enable = 1'b0;
    nt = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; cyc(); nt += int'(tick);
      step = 1'b0; cyc(); nt += int'(tick);
    end
    step = 1'b1; cyc(); nt += int'(tick);
    cyc(); nt += int'(tick);
    step = 1'b0;
    repeat (3) begin cyc(); nt += int'(tick); end
    chk("step_count", nt, 5);
    chk("step_pos", 32'(pos), 3);

    enable = 1'b1;
    wait_tick(n);
    chk("resume_period", n, 3);
    wait_tick(n);
    wait_tick(n);
    chk("pre_blink_pos", 32'(pos), 2);

    mode = 2'd3;
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      chk("blink_leds", 32'(leds), 32'(blink_seq[i]));
      chk("blink_pos", 32'(pos), 2);
    end
    mode = 2'd1;
    wait_tick(n);
    chk("leave_blink_leds", 32'(leds), 32'h2);
    chk("leave_blink_pos", 32'(pos), 1);

    step = 1'b1;
    wait_tick(n);
    chk("step_ignored_period", n, 4);
    step = 1'b0;

    mode = 2'd3;
    wait_tick(n);
    chk("blink_before_rst", 32'(leds), 32'hF);
    cyc();
    reset_n = 1'b0;
    #1;
    chk("async_rst_leds", 32'(leds), 32'h1);
    chk("async_rst_tick", 32'(tick), 32'h0);
    chk("async_rst_pos",  32'(pos),  32'h0);
    cyc(); cyc();
    reset_n = 1'b1; mode = 2'd0;
    wait_tick(n);
    chk("post_rst_period", n, 4);
    chk("post_rst_leds", 32'(leds), 32'h2);

`ifdef LED_CHASER_PWM_EN
    enable = 1'b0; step = 1'b0;
    brightness = 4'd4;
    cyc();
    cnt = 0;
    repeat (32) begin cyc(); cnt += int'(leds != '0); end
    chk("pwm_b4_on_cycles", cnt, 8);
    brightness = 4'd0;
    cyc();
    cnt = 0;
    repeat (16) begin cyc(); cnt += int'(leds != '0); end
    chk("pwm_b0_on_cycles", cnt, 0);
    brightness = 4'd15;
    cyc();
    cnt = 0;
    repeat (16) begin cyc(); cnt += int'(leds != '0); end
    chk("pwm_b15_on_cycles", cnt, 16);
`else
    cnt = 0;
`endif

    for (int i = 0; i < 800; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      enable  = ($urandom_range(0, 3) != 0);
      step    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
`ifdef LED_CHASER_PWM_EN
      if ($urandom_range(0, 15) == 0) brightness = 4'($urandom_range(0, 15));
`endif
      cyc();
    end
    reset_n = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
